// File: rtl/cnn_relu_maxpool_writer_pkg.sv
// cnn_relu_maxpool_writer_pkg: shared widths, pooling FSM states and a signed max helper
package cnn_relu_maxpool_writer_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int MAX_DIM   = 16;
  localparam int BUF_DEPTH = MAX_DIM / 2;
  localparam int IDX_W     = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} pool_state_t;
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction
endpackage

// File: rtl/cnn_relu_maxpool_writer_pool_row_buffer.sv
// cnn_relu_maxpool_writer_pool_row_buffer: one pooled row of even-row pair maxima (1 write, 1 async read port)
module cnn_relu_maxpool_writer_pool_row_buffer
  import cnn_relu_maxpool_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b)
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    else if (wr_en)
      mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/cnn_relu_maxpool_writer.sv
// cnn_relu_maxpool_writer: ReLU + 2x2/stride-2 max pool of a raster conv stream, written to SRAM
module cnn_relu_maxpool_writer
  import cnn_relu_maxpool_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              go,
  input  logic [4:0]        conv_dim,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              conv_valid,
  input  logic [DATA_W-1:0] conv_data,
  output logic              busy,
  output logic              done,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data
);
  pool_state_t state_q, state_d;
  logic [4:0] dim_q, col_q, p_side, dim_clamped;
  logic [3:0] pair_row_q;
  logic [DATA_W-1:0] pair_q, relu, pair_max, buf_rd;
  logic [ADDR_W-1:0] next_addr_q;
  logic start, accept, last_col, in_p, last_pair_row, buf_wr, pool_wr, frame_end;
  // Sides above the row buffer capacity are clamped so buffer indices stay in range
  assign dim_clamped   = (conv_dim > 5'(MAX_DIM)) ? 5'(MAX_DIM) : conv_dim;
  assign start         = go && state_q == IDLE;
  assign accept        = conv_valid && (state_q == EVEN_ROW || state_q == ODD_ROW);
  assign relu          = conv_data[DATA_W-1] ? '0 : conv_data;
  assign pair_max      = smax(pair_q, relu);
  // Effective side drops an odd trailing row/column
  assign p_side        = {dim_q[4:1], 1'b0};
  assign last_col      = col_q == dim_q - 5'd1;
  assign in_p          = col_q < p_side;
  assign last_pair_row = pair_row_q == dim_q[4:1] - 4'd1;
  assign buf_wr        = accept && state_q == EVEN_ROW && col_q[0] && in_p;
  assign pool_wr       = accept && state_q == ODD_ROW && col_q[0] && in_p;
  // Frame ends on the last pooled write; trailing odd samples arrive after and are ignored
  assign frame_end     = pool_wr && last_pair_row && col_q == p_side - 5'd1;
  // DONE lasts one cycle; done is registered off it so it follows the final write by a cycle
  assign busy          = state_q != IDLE;
  cnn_relu_maxpool_writer_pool_row_buffer u_buf (
    .clk     (clk),
    .reset_b (reset_b),
    .wr_en   (buf_wr),
    .wr_idx  (col_q[IDX_W:1]),
    .wr_data (pair_max),
    .rd_idx  (col_q[IDX_W:1]),
    .rd_data (buf_rd)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = !go ? IDLE : (dim_clamped[4:1] == 4'd0) ? DONE : EVEN_ROW;
      EVEN_ROW: state_d = (accept && last_col) ? ODD_ROW : EVEN_ROW;
      ODD_ROW:  state_d = frame_end ? DONE : (accept && last_col) ? EVEN_ROW : ODD_ROW;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      dim_q              <= '0;
      col_q              <= '0;
      pair_row_q         <= '0;
      pair_q             <= '0;
      next_addr_q        <= '0;
      done               <= 1'b0;
      sram_write_enable  <= 1'b0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
    end else begin
      done              <= state_q == DONE;
      sram_write_enable <= pool_wr;
      if (start) begin
        dim_q       <= dim_clamped;
        col_q       <= '0;
        pair_row_q  <= '0;
        next_addr_q <= out_base;
      end else if (accept) begin
        col_q <= last_col ? 5'd0 : col_q + 5'd1;
        if (last_col && state_q == ODD_ROW) pair_row_q <= pair_row_q + 4'd1;
        if (!col_q[0]) pair_q <= relu;
      end
      if (pool_wr) begin
        sram_write_data    <= smax(buf_rd, pair_max);
        sram_write_address <= next_addr_q;
        next_addr_q        <= next_addr_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_cnn_relu_maxpool_writer.sv
// tb_cnn_relu_maxpool_writer: scoreboard bench for ReLU/maxpool SRAM writer
module tb_cnn_relu_maxpool_writer;
  logic clk = 0, reset_b = 0, go = 0, conv_valid = 0;
  logic [4:0] conv_dim = 0;
  logic [11:0] out_base = 0;
  logic [15:0] conv_data = 0;
  logic busy, done, sram_write_enable;
  logic [11:0] sram_write_address;
  logic [15:0] sram_write_data;
  int checks = 0, failures = 0;
  typedef struct {logic [11:0] a; logic [15:0] d;} wr_t;
  wr_t exp_q[$];

  cnn_relu_maxpool_writer dut (
    .clk(clk), .reset_b(reset_b), .go(go), .conv_dim(conv_dim), .out_base(out_base),
    .conv_valid(conv_valid), .conv_data(conv_data), .busy(busy), .done(done),
    .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sram_write_enable) begin
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_write got addr=%h data=%h want none", sram_write_address, sram_write_data);
    end else begin
      e = exp_q.pop_front();
      if (sram_write_address !== e.a || sram_write_data !== e.d) begin
        failures++;
        $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                 sram_write_address, sram_write_data, e.a, e.d);
      end
    end
  end

  task automatic push_model(input int dim, input logic [11:0] base, input logic [15:0] s[]);
    int p, k, m, v;
    p = dim & ~1;
    k = 0;
    for (int pr = 0; pr < p / 2; pr++)
      for (int pc = 0; pc < p / 2; pc++) begin
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = int'($signed(s[(2 * pr + dr) * dim + 2 * pc + dc]));
            if (v > m) m = v;
          end
        exp_q.push_back('{base + 12'(k), 16'(m)});
        k++;
      end
  endtask

  task automatic run_frame(input string name, input int dim, input logic [11:0] base,
                           input int mode, input bit stall, input bit mid_go);
    logic [15:0] s[];
    int n;
    n = dim * dim;
    s = new[n];
    for (int i = 0; i < n; i++)
      s[i] = (mode == 0) ? 16'(i + 1) : (mode == 1) ? 16'hFFFB : 16'($urandom);
    push_model(dim, base, s);
    @(posedge clk); #1;
    go = 1; conv_dim = 5'(dim); out_base = base;
    @(posedge clk); #1;
    go = 0; conv_dim = 0; out_base = 0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_start got=%b want=1", name, busy); end
    for (int i = 0; i < n; i++) begin
      if (stall) begin conv_valid = 0; @(posedge clk); #1; end
      conv_valid = 1; conv_data = s[i];
      if (mid_go && i == 5) begin go = 1; conv_dim = 5'd2; out_base = 12'h555; end
      else go = 0;
      @(posedge clk); #1;
    end
    conv_valid = 0; go = 0; conv_dim = 0; out_base = 0;
    if (dim % 2 == 0) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL %s_tail1 got done=%b busy=%b want done=0 busy=1", name, done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL %s_done got done=%b busy=%b want done=1 busy=0", name, done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
    end else begin
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL %s_idle got busy=%b done=%b want 0 0", name, busy, done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL %s_missing_writes got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (busy !== 0 || done !== 0 || sram_write_enable !== 0 || sram_write_address !== 0 || sram_write_data !== 0) begin
      failures++;
      $display("FAIL %s got busy=%b done=%b we=%b addr=%h data=%h want all 0", name, busy, done,
               sram_write_enable, sram_write_address, sram_write_data);
    end
  endtask

  task automatic test_reset();
    reset_b = 0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    reset_b = 1;
  endtask

  task automatic test_basic();
    run_frame("basic", 4, 12'h100, 0, 0, 0);
  endtask

  task automatic test_relu();
    run_frame("relu", 4, 12'h020, 1, 0, 0);
  endtask

  task automatic test_wrap();
    run_frame("wrap", 5, 12'hFFE, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_frame("stall", 4, 12'h100, 0, 1, 1);
  endtask

  task automatic test_random();
    run_frame("rand6", 6, 12'h040, 2, 0, 0);
    run_frame("rand16", 16, 12'h7F0, 2, 0, 0);
  endtask

  task automatic test_abort();
    exp_q.push_back('{12'h300, 16'd6});
    @(posedge clk); #1;
    go = 1; conv_dim = 5'd4; out_base = 12'h300;
    @(posedge clk); #1;
    go = 0;
    for (int i = 0; i < 6; i++) begin
      conv_valid = 1; conv_data = 16'(i + 1);
      @(posedge clk); #1;
    end
    conv_valid = 0;
    checks++;
    if (sram_write_enable !== 1'b1) begin failures++; $display("FAIL abort_first_write got=%b want=1", sram_write_enable); end
    @(negedge clk); #2;
    reset_b = 0;
    #1 check_zero_outputs("abort_reset");
    conv_valid = 1; conv_data = 16'd99;
    repeat (3) @(posedge clk);
    #1 reset_b = 1;
    repeat (4) @(posedge clk);
    #1 conv_valid = 0;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL abort_idle got busy=%b pending=%0d want 0 0", busy, exp_q.size());
      exp_q.delete();
    end
    run_frame("after_abort", 4, 12'h200, 0, 0, 0);
  endtask

  task automatic test_dim1();
    @(posedge clk); #1;
    go = 1; conv_dim = 5'd1; out_base = 12'h010;
    @(posedge clk); #1;
    go = 0; conv_dim = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL dim1_cycle1 got busy=%b done=%b want 1 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL dim1_done got busy=%b done=%b want 0 1", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL dim1_done_pulse got=%b want=0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_wrap();
    test_stall();
    test_random();
    test_abort();
    test_dim1();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
